cmd_fifo_param: RTL and testbench

// - Parametrised synchronous circular-buffer FIFO for the 2D GPU command path; successor to the fixed 82-bit/4-deep command FIFO.
// - Buffers packed draw-command words between the host/APB input decoder and the rasteriser/pixel pipeline.
// - Adds configurable width/depth, concurrent read+write, occupancy count and almost-full back-pressure.

---
 rtl/cmd_fifo_param.sv | 96 +++++++++
 tb/tb_cmd_fifo_param.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cmd_fifo_param.sv
// Parametrised circular-buffer command FIFO with occupancy count and almost-full back-pressure.
// Optional sticky overflow/underflow flags are built when CMD_FIFO_ERR_EN is defined.
module cmd_fifo_param #(
   parameter  int DATA_W    = 82,
   parameter  int DEPTH     = 4,
   parameter  int AF_THRESH = 3,
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              w_enable,
   input  logic [DATA_W-1:0] w_data,
   input  logic              r_enable,
   output logic [DATA_W-1:0] r_data,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
`ifdef CMD_FIFO_ERR_EN
   input  logic              err_clr,
   output logic              overflow,
   output logic              underflow,
`endif
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              wr_acc;
   logic              rd_acc;

   // Flags are decoded from the registered count only, never from the request inputs.
   assign empty       = (count == '0);
   assign full        = (count == CNT_W'(DEPTH));
   assign almost_full = (count >= CNT_W'(AF_THRESH));

   assign wr_acc = w_enable & ~full;
   assign rd_acc = r_enable & ~empty;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      // Explicit wrap so DEPTH need not be a power of two.
      if (p == PTR_W'(DEPTH - 1))
         return '0;
      else
         return p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         r_data <= '0;
      end else begin
         if (wr_acc)
            wr_ptr <= ptr_inc(wr_ptr);
         if (rd_acc) begin
            rd_ptr <= ptr_inc(rd_ptr);
            r_data <= mem[rd_ptr];
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; writes are suppressed while reset is held.
   always_ff @(posedge clk) begin
      if (n_rst && wr_acc)
         mem[wr_ptr] <= w_data;
   end

`ifdef CMD_FIFO_ERR_EN
   // Sticky error flags: a new violation takes priority over a coincident clear.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (w_enable && full)
            overflow <= 1'b1;
         else if (err_clr)
            overflow <= 1'b0;
         if (r_enable && empty)
            underflow <= 1'b1;
         else if (err_clr)
            underflow <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_cmd_fifo_param.sv
// Directed self-checking bench for cmd_fifo_param at DATA_W=82, DEPTH=4, AF_THRESH=3.
// Error-flag scenario is compiled in only when CMD_FIFO_ERR_EN is defined.
module tb_cmd_fifo_param;

   localparam int DATA_W = 82;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              n_rst;
   logic              w_enable;
   logic [DATA_W-1:0] w_data;
   logic              r_enable;
   logic [DATA_W-1:0] r_data;
   logic              empty;
   logic              full;
   logic              almost_full;
   logic [CNT_W-1:0]  count;
`ifdef CMD_FIFO_ERR_EN
   logic              err_clr;
   logic              overflow;
   logic              underflow;
`endif

   int checks   = 0;
   int failures = 0;

   cmd_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(3)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .w_enable    (w_enable),
      .w_data      (w_data),
      .r_enable    (r_enable),
      .r_data      (r_data),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
`ifdef CMD_FIFO_ERR_EN
      .err_clr     (err_clr),
      .overflow    (overflow),
      .underflow   (underflow),
`endif
      .count       (count)
   );

   always #5 clk = ~clk;

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [DATA_W-1:0] wd, input logic re);
      w_enable = we;
      w_data   = wd;
      r_enable = re;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      drive(1'b0, '0, 1'b0);
      tick();
      tick();
      n_rst = 1'b1;
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
      checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_af got=%0b exp=0", almost_full); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (r_data !== 82'h0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", r_data); end
`ifdef CMD_FIFO_ERR_EN
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b%0b exp=00", overflow, underflow); end
`endif
   endtask

   task automatic test_fill_drain();
      logic [DATA_W-1:0] vals [4];
      vals[0] = 82'hA; vals[1] = 82'hB; vals[2] = 82'hC; vals[3] = 82'hD;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, vals[i], 1'b0);
         tick();
         checks++; if (count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
         checks++; if (almost_full !== (i + 1 >= 3)) begin failures++; $display("FAIL fill_af[%0d] got=%0b exp=%0b", i, almost_full, (i + 1 >= 3)); end
         checks++; if (full !== (i == 3)) begin failures++; $display("FAIL fill_full[%0d] got=%0b exp=%0b", i, full, (i == 3)); end
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, '0, 1'b1);
         tick();
         checks++; if (r_data !== vals[i]) begin failures++; $display("FAIL drain_rdata[%0d] got=%0h exp=%0h", i, r_data, vals[i]); end
         checks++; if (count !== 3'(3 - i)) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 3 - i); end
      end
      drive(1'b0, '0, 1'b0);
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%0b exp=1", empty); end
   endtask

   task automatic test_wrap();
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, DATA_W'(i), 1'b0);
         tick();
      end
      for (int i = 1; i <= 2; i++) begin
         drive(1'b0, '0, 1'b1);
         tick();
         checks++; if (r_data !== DATA_W'(i)) begin failures++; $display("FAIL wrap_rd_a[%0d] got=%0h exp=%0h", i, r_data, i); end
      end
      for (int i = 4; i <= 6; i++) begin
         drive(1'b1, DATA_W'(i), 1'b0);
         tick();
      end
      checks++; if (full !== 1'b1) begin failures++; $display("FAIL wrap_full got=%0b exp=1", full); end
      for (int i = 3; i <= 6; i++) begin
         drive(1'b0, '0, 1'b1);
         tick();
         checks++; if (r_data !== DATA_W'(i)) begin failures++; $display("FAIL wrap_rd_b[%0d] got=%0h exp=%0h", i, r_data, i); end
      end
      drive(1'b0, '0, 1'b0);
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL wrap_count got=%0d exp=0", count); end
   endtask

   task automatic test_simultaneous();
      drive(1'b1, 82'h10, 1'b0); tick();
      drive(1'b1, 82'h11, 1'b0); tick();
      drive(1'b1, 82'h12, 1'b1); tick();
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL rw_mid_count got=%0d exp=2", count); end
      checks++; if (r_data !== 82'h10) begin failures++; $display("FAIL rw_mid_rdata got=%0h exp=10", r_data); end
      drive(1'b1, 82'h13, 1'b0); tick();
      drive(1'b1, 82'h14, 1'b0); tick();
      checks++; if (full !== 1'b1) begin failures++; $display("FAIL rw_prefull got=%0b exp=1", full); end
      drive(1'b1, 82'h15, 1'b1); tick();
      checks++; if (count !== 3'd3) begin failures++; $display("FAIL rw_full_count got=%0d exp=3", count); end
      checks++; if (r_data !== 82'h11) begin failures++; $display("FAIL rw_full_rdata got=%0h exp=11", r_data); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, 1'b1);
         tick();
         checks++; if (r_data !== DATA_W'(8'h12 + i)) begin failures++; $display("FAIL rw_rest[%0d] got=%0h exp=%0h", i, r_data, 8'h12 + i); end
      end
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rw_empty got=%0b exp=1", empty); end
      drive(1'b1, 82'h16, 1'b1); tick();
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL rw_empty_count got=%0d exp=1", count); end
      checks++; if (r_data !== 82'h14) begin failures++; $display("FAIL rw_empty_rdata got=%0h exp=14", r_data); end
      drive(1'b0, '0, 1'b1); tick();
      checks++; if (r_data !== 82'h16) begin failures++; $display("FAIL rw_empty_follow got=%0h exp=16", r_data); end
      drive(1'b0, '0, 1'b0);
   endtask

`ifdef CMD_FIFO_ERR_EN
   task automatic test_errors();
      err_clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, DATA_W'(8'h20 + i), 1'b0);
         tick();
      end
      drive(1'b1, 82'h24, 1'b0); tick();
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL err_overflow got=%0b exp=1", overflow); end
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL err_ovf_count got=%0d exp=4", count); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, '0, 1'b1);
         tick();
         checks++; if (r_data !== DATA_W'(8'h20 + i)) begin failures++; $display("FAIL err_intact[%0d] got=%0h exp=%0h", i, r_data, 8'h20 + i); end
      end
      drive(1'b0, '0, 1'b1); tick();
      checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL err_underflow got=%0b exp=1", underflow); end
      checks++; if (r_data !== 82'h23) begin failures++; $display("FAIL err_udf_rdata got=%0h exp=23", r_data); end
      drive(1'b0, '0, 1'b0);
      err_clr = 1'b1; tick();
      err_clr = 1'b0;
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL err_clear got=%0b%0b exp=00", overflow, underflow); end
   endtask
`endif

   task automatic test_mid_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, DATA_W'(8'h30 + i), 1'b0);
         tick();
      end
      checks++; if (count !== 3'd3) begin failures++; $display("FAIL mr_pre_count got=%0d exp=3", count); end
      n_rst = 1'b0;
      drive(1'b1, 82'h33, 1'b0);
      tick();
      n_rst = 1'b1;
      drive(1'b0, '0, 1'b0);
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL mr_count got=%0d exp=0", count); end
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL mr_empty got=%0b exp=1", empty); end
      drive(1'b1, 82'h40, 1'b0); tick();
      drive(1'b0, '0, 1'b1); tick();
      drive(1'b0, '0, 1'b0);
      checks++; if (r_data !== 82'h40) begin failures++; $display("FAIL mr_rdata got=%0h exp=40", r_data); end
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL mr_end_empty got=%0b exp=1", empty); end
   endtask

   initial begin
      n_rst    = 1'b0;
      w_enable = 1'b0;
      w_data   = '0;
      r_enable = 1'b0;
`ifdef CMD_FIFO_ERR_EN
      err_clr  = 1'b0;
`endif
      test_reset();
      test_fill_drain();
      test_wrap();
      test_simultaneous();
`ifdef CMD_FIFO_ERR_EN
      test_errors();
`endif
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
